if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter IM_WORDS, default 256, meaning the instruction-memory depth in 32-bit words.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_i  input  1  hazard-unit hold request for the PC and IF/ID.
REQ-006 SHALL have port redirect_i  input  1  branch/jump resolved in ID or EX; load redirect_pc_i.
REQ-007 SHALL have port redirect_pc_i  input  32  redirect target.
REQ-008 SHALL have port im_addr_o  output  32  byte address to the instruction memory, equal to the current PC.
REQ-009 SHALL have port im_data_i  input  32  combinational instruction word at im_addr_o.
REQ-010 SHALL have port if_id_pc4_o  output  32  registered PC+4 of the fetched instruction.
REQ-011 SHALL have port if_id_instr_o  output  32  registered instruction word.
REQ-012 SHALL have port if_id_valid_o  output  1  registered flag; the IF/ID contents are a real instruction.
REQ-013 SHALL have port if_id_pred_o  output  1  registered flag; the fetch was predicted taken.
REQ-014 SHALL have port fetch_cnt_o  output  32  count of valid instructions loaded into IF/ID.

Function
REQ-015 SHALL drive im_addr_o as the PC register, with no combinational path from im_data_i.
REQ-016 SHALL give one-cycle latency: the word fetched while im_addr_o = A appears in IF/ID on the next rising edge, with pc4 = A+4.
REQ-017 SHALL apply next-state priority per edge: redirect_i, then stall_i, then normal fetch.
REQ-018 SHALL, on redirect, load PC with {redirect_pc_i[31:2],2'b00} and load IF/ID with instr 0, valid 0, pred 0 (flush), even if stall_i is high.
REQ-019 SHALL, on stall without redirect, hold PC and all IF/ID registers unchanged and not increment fetch_cnt_o.
REQ-020 SHALL, on normal fetch, load PC with the predicted next PC (PC+4 unless REQ-030 applies) and load IF/ID with im_data_i, pc4 = PC+4, valid 1.
REQ-021 SHALL, when PC[31:2] >= IM_WORDS on a normal fetch, load IF/ID with instr 0, valid 0 and still advance the PC.
REQ-022 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-023 SHALL increment fetch_cnt_o by 1 on each edge that loads valid 1, saturating at 32'hFFFF_FFFF.

Reset
REQ-024 SHALL, while rst_i is low, asynchronously force PC = RESET_PC, if_id_pc4_o = 0, if_id_instr_o = 0, if_id_valid_o = 0, if_id_pred_o = 0, fetch_cnt_o = 0.
REQ-025 SHALL, on the first rising edge after rst_i goes high, perform a normal fetch at RESET_PC.
REQ-026 SHALL, on reset assertion mid-stall or mid-redirect, discard the pending operation with no residual state.

Configuration
REQ-027 SHALL gate static backward-taken/forward-not-taken prediction with macro IF_STAGE_BTFN_PREDICT_EN.
REQ-028 SHALL, without the macro, always use PC+4 as the next PC on a normal fetch and tie if_id_pred_o to 0.
REQ-029 SHALL, with the macro, treat im_data_i[31:26] = 6'b000100 (beq) with im_data_i[15] = 1 as predicted taken.
REQ-030 SHALL, for a predicted-taken fetch, set the next PC to PC+4+(sign-extended imm16 << 2) and load if_id_pred_o = 1; ID corrects mispredictions via redirect_i.

Structure
REQ-031 SHALL take OPC_BEQ, NOP_INSTR (32'h0) and the 32-bit address width from the shared package pipe_cpu_pkg.
REQ-032 SHALL place next-PC selection in one combinational sub-module, if_next_pc; PC, IF/ID and the counter stay in if_stage.

Verification
REQ-033 SHALL cover: reset release, memory {w0,w1,w2} at 0,4,8 -> im_addr_o 0,4,8 on successive cycles; IF/ID shows w0/pc4 4 one cycle after fetch; fetch_cnt_o = 3 after three edges.
REQ-034 SHALL cover: stall_i high for 2 cycles at PC 8 -> PC stays 8, IF/ID holds w1/pc4 8, fetch_cnt_o unchanged.
REQ-035 SHALL cover: redirect_i with stall_i high, target 32'h0000_0023 -> PC 32'h20, IF/ID valid 0, instr 0.
REQ-036 SHALL cover: IM_WORDS = 4, PC reaches 16 -> IF/ID valid 0, PC advances to 20, counter unchanged.
REQ-037 SHALL cover: macro defined, beq imm 16'hFFFE at PC 12 -> next PC 8, if_id_pred_o 1; macro undefined -> next PC 16, pred 0.
REQ-038 SHALL cover: rst_i low mid-stream at PC 40 -> all outputs zero and PC = RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_cpu_pkg.sv
// Shared pipeline definitions: opcode constants, address width, the
// per-edge IF action encoding and the beq branch-offset helper.
package pipe_cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0]      OPC_BEQ   = 6'b000100;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // What the fetch stage does on the coming rising edge.
    typedef enum logic [1:0] {
        ACT_FETCH    = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } if_act_e;

    // Sign-extended word offset of a beq immediate, in bytes.
    function automatic logic [XLEN-1:0] beq_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC selection for the fetch stage.
// Priority per edge: redirect, then stall, then (predicted) sequential fetch.
// Static backward-taken prediction of beq is enabled by the macro
// IF_STAGE_BTFN_PREDICT_EN; without it the fetch path is always PC+4.
module if_next_pc
    import pipe_cpu_pkg::*;
#(
    parameter int IM_WORDS = 256
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic [5:0]      opc_i,
    input  logic [15:0]     imm_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            in_range_o,
    output logic            pred_taken_o,
    output if_act_e         act_o
);

`ifdef IF_STAGE_BTFN_PREDICT_EN
    localparam bit BTFN_EN = 1'b1;
`else
    localparam bit BTFN_EN = 1'b0;
`endif

    localparam logic [XLEN-1:0] IM_LIMIT = XLEN'(IM_WORDS);

    // Decode the fetched word and pick the PC for the next edge.
    always_comb begin
        pc_plus4_o   = pc_i + 32'd4;
        in_range_o   = ({2'b00, pc_i[XLEN-1:2]} < IM_LIMIT);
        // Only a real (in-range) backward beq is predicted taken.
        pred_taken_o = BTFN_EN && in_range_o && (opc_i == OPC_BEQ) && imm_i[15];
        if (redirect_i) begin
            act_o     = ACT_REDIRECT;
            pc_next_o = redirect_pc_i & ~32'h0000_0003;
        end else if (stall_i) begin
            act_o     = ACT_STALL;
            pc_next_o = pc_i;
        end else begin
            act_o     = ACT_FETCH;
            pc_next_o = pred_taken_o ? (pc_plus4_o + beq_offset(imm_i)) : pc_plus4_o;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a
// saturating count of valid fetches. Next-PC choice lives in if_next_pc.
// Optional feature macro: IF_STAGE_BTFN_PREDICT_EN (static BTFN prediction).
module if_stage
    import pipe_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_data_i,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        if_id_pred_o,
    output logic [31:0] fetch_cnt_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            pred_q, pred_d;
    logic [XLEN-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;
    logic            in_range;
    logic            pred_taken;
    if_act_e         act;

    if_next_pc #(
        .IM_WORDS (IM_WORDS)
    ) u_next_pc (
        .pc_i          (pc_q),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .opc_i         (im_data_i[31:26]),
        .imm_i         (im_data_i[15:0]),
        .pc_next_o     (pc_next),
        .pc_plus4_o    (pc_plus4),
        .in_range_o    (in_range),
        .pred_taken_o  (pred_taken),
        .act_o         (act)
    );

    // Next state of PC, IF/ID and the fetch counter for the chosen action.
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pred_d  = pred_q;
        cnt_d   = cnt_q;
        case (act)
            ACT_REDIRECT: begin
                // Flush: the word at the old PC is on the wrong path.
                pc_d    = pc_next;
                pc4_d   = '0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                pred_d  = 1'b0;
            end
            ACT_FETCH: begin
                pc_d  = pc_next;
                pc4_d = pc_plus4;
                if (in_range) begin
                    instr_d = im_data_i;
                    valid_d = 1'b1;
                    pred_d  = pred_taken;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
                end else begin
                    // Past the end of instruction memory: bubble, PC still moves.
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    pred_d  = 1'b0;
                end
            end
            default: ; // stall holds everything
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= RESET_PC;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            pred_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pred_q  <= pred_d;
            cnt_q   <= cnt_d;
        end
    end

    assign im_addr_o     = pc_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_instr_o = instr_q;
    assign if_id_valid_o = valid_q;
    assign if_id_pred_o  = pred_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage (IM_WORDS = 4, RESET_PC = 0).
// Expectations follow IF_STAGE_BTFN_PREDICT_EN when it is defined.
module tb_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] im_addr_o;
    logic [31:0] im_data_i;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        if_id_pred_o;
    logic [31:0] fetch_cnt_o;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] W0  = 32'h1111_1111;
    localparam logic [31:0] W1  = 32'h2222_2222;
    localparam logic [31:0] W2  = 32'h3333_3333;
    localparam logic [31:0] BEQ = 32'h1022_FFFE; // beq, imm -2 words

    logic [31:0] mem [0:15];
    assign im_data_i = mem[im_addr_o[5:2]];

    always #5 clk_i = ~clk_i;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .IM_WORDS (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .im_addr_o     (im_addr_o),
        .im_data_i     (im_data_i),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_valid_o (if_id_valid_o),
        .if_id_pred_o  (if_id_pred_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        valid;
        logic        pred;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, ".pc"},    im_addr_o, 32'h0);
        chk({tag, ".pc4"},   if_id_pc4_o, 32'h0);
        chk({tag, ".instr"}, if_id_instr_o, 32'h0);
        chk({tag, ".valid"}, {31'b0, if_id_valid_o}, 32'h0);
        chk({tag, ".pred"},  {31'b0, if_id_pred_o}, 32'h0);
        chk({tag, ".cnt"},   fetch_cnt_o, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = BEQ;

        //           stall redir rpc            pc             instr pc4       chk  v  p  cnt
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h4,         W0,   32'h4,    1'b1, 1'b1, 1'b0, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h8,         W1,   32'h8,    1'b1, 1'b1, 1'b0, 32'd2};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,         32'h8,         W1,   32'h8,    1'b1, 1'b1, 1'b0, 32'd2};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         32'h8,         W1,   32'h8,    1'b1, 1'b1, 1'b0, 32'd2};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         32'hC,         W2,   32'hC,    1'b1, 1'b1, 1'b0, 32'd3};
`ifdef IF_STAGE_BTFN_PREDICT_EN
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         32'h8,         BEQ,  32'h10,   1'b1, 1'b1, 1'b1, 32'd4};
`else
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         32'h10,        BEQ,  32'h10,   1'b1, 1'b1, 1'b0, 32'd4};
`endif
        vecs[6]  = '{1'b1, 1'b1, 32'h13,        32'h10,        32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'd4};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'h14,        32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'd4};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         32'h18,        32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'd4};
        vecs[9]  = '{1'b1, 1'b1, 32'h23,        32'h20,        32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'd4};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'd4};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'd4};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         32'h4,         W0,   32'h4,    1'b1, 1'b1, 1'b0, 32'd5};
        vecs[13] = '{1'b0, 1'b1, 32'h28,        32'h28,        32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'd5};

        rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        #2;
        chk_all_reset("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        chk("release.pc", im_addr_o, 32'h0);
        $display("[TB] reset released, pc=%h", im_addr_o);

        for (int i = 0; i < NV; i++) begin
            stall_i       = vecs[i].stall;
            redirect_i    = vecs[i].redirect;
            redirect_pc_i = vecs[i].rpc;
            @(posedge clk_i); #1;
            chk($sformatf("v%0d.pc", i),    im_addr_o, vecs[i].pc);
            chk($sformatf("v%0d.instr", i), if_id_instr_o, vecs[i].instr);
            if (vecs[i].chk_pc4) chk($sformatf("v%0d.pc4", i), if_id_pc4_o, vecs[i].pc4);
            chk($sformatf("v%0d.valid", i), {31'b0, if_id_valid_o}, {31'b0, vecs[i].valid});
            chk($sformatf("v%0d.pred", i),  {31'b0, if_id_pred_o}, {31'b0, vecs[i].pred});
            chk($sformatf("v%0d.cnt", i),   fetch_cnt_o, vecs[i].cnt);
            $display("[TB] v%0d st=%0b rd=%0b -> pc=%h instr=%h pc4=%h v=%0b p=%0b cnt=%0d",
                     i, vecs[i].stall, vecs[i].redirect, im_addr_o, if_id_instr_o,
                     if_id_pc4_o, if_id_valid_o, if_id_pred_o, fetch_cnt_o);
        end

        // Asynchronous reset in the middle of a stall at PC 40, between edges.
        stall_i = 1'b1; redirect_i = 1'b0;
        #1;
        rst_i = 1'b0;
        #1;
        chk_all_reset("async_rst");
        $display("[TB] async reset mid-stall -> pc=%h cnt=%0d", im_addr_o, fetch_cnt_o);

        // Pending redirect while reset is held must leave no trace.
        stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40;
        @(posedge clk_i); #1;
        chk_all_reset("rst_held");
        rst_i = 1'b1; redirect_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post_rst.pc",    im_addr_o, 32'h4);
        chk("post_rst.instr", if_id_instr_o, W0);
        chk("post_rst.pc4",   if_id_pc4_o, 32'h4);
        chk("post_rst.valid", {31'b0, if_id_valid_o}, 32'h1);
        chk("post_rst.cnt",   fetch_cnt_o, 32'd1);
        $display("[TB] first fetch after reset -> pc=%h instr=%h cnt=%0d",
                 im_addr_o, if_id_instr_o, fetch_cnt_o);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
